// File: rtl/timer_pkg.sv
// Shared types and constants for the microwave cook-time counter.
package timer_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_ZERO = 4'd0;
  localparam bcd_t BCD_FIVE = 4'd5;
  localparam bcd_t BCD_NINE = 4'd9;

  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/timer_counter_edge_sync.sv
// Multi-flop synchronizer followed by a one-flop edge detector.
// RISING = 1 detects low-to-high; RISING = 0 detects high-to-low.
module edge_sync
  import timer_pkg::*;
#(
  parameter int STAGES = DEFAULT_SYNC_STAGES,
  parameter bit RISING = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic evt_o
);

  // Flops reset to the idle level so that leaving reset never produces an edge.
  localparam logic IDLE = RISING ? 1'b0 : 1'b1;

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              synced;

  assign synced = sync_q[STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{IDLE}};
      prev_q <= IDLE;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], sig_i};
      prev_q <= synced;
    end
  end

  assign evt_o = RISING ? (synced & ~prev_q) : (~synced & prev_q);

endmodule

// File: rtl/timer_counter.sv
// Three-digit BCD cook timer: shift-in entry while idle, 1 Hz countdown while cooking.
// Optional TIMER_DONE_PULSE_EN adds a one-cycle 'done' pulse on reaching 0:00 by counting.
module timer_counter
  import timer_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic [3:0] BCD_IN,
  input  logic       loadn,
  input  logic       pgt_1hz,
  input  logic       enablen,
  output logic [3:0] mins,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       zero
`ifdef TIMER_DONE_PULSE_EN
  ,
  output logic       done
`endif
);

  logic load_evt;
  logic tick_evt;

  edge_sync #(.STAGES(SYNC_STAGES), .RISING(1'b0)) u_load_sync (
    .clk_i (clk),
    .rst_ni(clearn),
    .sig_i (loadn),
    .evt_o (load_evt)
  );

  edge_sync #(.STAGES(SYNC_STAGES), .RISING(1'b1)) u_tick_sync (
    .clk_i (clk),
    .rst_ni(clearn),
    .sig_i (pgt_1hz),
    .evt_o (tick_evt)
  );

  bcd_t mins_q, tens_q, ones_q;
  bcd_t mins_d, tens_d, ones_d;
  logic load_en, step_en;

  assign load_en = enablen & load_evt & (BCD_IN <= BCD_NINE);
  assign step_en = ~enablen & tick_evt;

  // Entry and countdown are mutually exclusive through enablen.
  always_comb begin
    mins_d = mins_q;
    tens_d = tens_q;
    ones_d = ones_q;
    if (load_en) begin
      mins_d = tens_q;
      tens_d = ones_q;
      ones_d = BCD_IN;
    end else if (step_en) begin
      if (ones_q != BCD_ZERO) begin
        ones_d = ones_q - 4'd1;
      end else if (tens_q != BCD_ZERO) begin
        tens_d = tens_q - 4'd1;
        ones_d = BCD_NINE;
      end else if (mins_q != BCD_ZERO) begin
        mins_d = mins_q - 4'd1;
        tens_d = BCD_FIVE;
        ones_d = BCD_NINE;
      end
    end
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      mins_q <= BCD_ZERO;
      tens_q <= BCD_ZERO;
      ones_q <= BCD_ZERO;
    end else begin
      mins_q <= mins_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign mins     = mins_q;
  assign sec_tens = tens_q;
  assign sec_ones = ones_q;
  assign zero     = (mins_q == BCD_ZERO) && (tens_q == BCD_ZERO) && (ones_q == BCD_ZERO);

`ifdef TIMER_DONE_PULSE_EN
  logic done_q, done_d;

  // Only a real countdown step from nonzero to all-zero fires the pulse.
  assign done_d = step_en & ~zero &
                  (mins_d == BCD_ZERO) & (tens_d == BCD_ZERO) & (ones_d == BCD_ZERO);

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done = done_q;
`endif

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter (default SYNC_STAGES = 2).
module tb_timer_counter;

  logic       clk = 1'b0;
  logic       clearn;
  logic [3:0] BCD_IN;
  logic       loadn;
  logic       pgt_1hz;
  logic       enablen;
  logic [3:0] mins, sec_tens, sec_ones;
  logic       zero;
  int         checks = 0;
  int         errors = 0;

`ifdef TIMER_DONE_PULSE_EN
  logic done;
  int   done_count = 0;
  bit   count_done = 1'b0;
`endif

  always #5 clk = ~clk;

  timer_counter dut (
    .clk     (clk),
    .clearn  (clearn),
    .BCD_IN  (BCD_IN),
    .loadn   (loadn),
    .pgt_1hz (pgt_1hz),
    .enablen (enablen),
    .mins    (mins),
    .sec_tens(sec_tens),
    .sec_ones(sec_ones),
    .zero    (zero)
`ifdef TIMER_DONE_PULSE_EN
    ,
    .done    (done)
`endif
  );

`ifdef TIMER_DONE_PULSE_EN
  always @(negedge clk) begin
    if (count_done && done === 1'b1) done_count++;
  end
`endif

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key(input logic [3:0] d);
    BCD_IN = d;
    loadn  = 1'b0;
    idle(5);
    loadn  = 1'b1;
    idle(5);
  endtask

  task automatic tick();
    pgt_1hz = 1'b1;
    idle(4);
    pgt_1hz = 1'b0;
    idle(4);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clearn = 1'b0;
    idle(2);
    clearn = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    clearn = 1'b0; loadn = 1'b1; pgt_1hz = 1'b0; enablen = 1'b1; BCD_IN = 4'd0;
    idle(3);
    checks++;
    if ({mins, sec_tens, sec_ones} !== 12'h000 || zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h zero=%b, want 000 zero=1", {mins, sec_tens, sec_ones}, zero);
    end
`ifdef TIMER_DONE_PULSE_EN
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_done: got %b, want 0", done);
    end
`endif
    clearn  = 1'b1;
    enablen = 1'b0;
    idle(2);
    repeat (3) tick();
    checks++;
    if ({mins, sec_tens, sec_ones} !== 12'h000 || zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_ticks_at_zero: got %h zero=%b, want 000 zero=1", {mins, sec_tens, sec_ones}, zero);
    end
  endtask

  task automatic test_entry();
    do_reset();
    enablen = 1'b1;
    press_key(4'd1);
    checks++;
    if ({mins, sec_tens, sec_ones} !== 12'h001) begin
      errors++;
      $display("[TB] FAIL entry_1: got %h, want 001", {mins, sec_tens, sec_ones});
    end
    press_key(4'd3);
    checks++;
    if ({mins, sec_tens, sec_ones} !== 12'h013) begin
      errors++;
      $display("[TB] FAIL entry_13: got %h, want 013", {mins, sec_tens, sec_ones});
    end
    press_key(4'd0);
    checks++;
    if ({mins, sec_tens, sec_ones} !== 12'h130 || zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL entry_130: got %h zero=%b, want 130 zero=0", {mins, sec_tens, sec_ones}, zero);
    end
  endtask

  task automatic test_invalid();
    press_key(4'd12);
    checks++;
    if ({mins, sec_tens, sec_ones} !== 12'h130) begin
      errors++;
      $display("[TB] FAIL invalid_digit: got %h, want 130", {mins, sec_tens, sec_ones});
    end
  endtask

  task automatic test_held_key();
    BCD_IN = 4'd7;
    loadn  = 1'b0;
    idle(50);
    checks++;
    if ({mins, sec_tens, sec_ones} !== 12'h307) begin
      errors++;
      $display("[TB] FAIL held_key: got %h, want 307", {mins, sec_tens, sec_ones});
    end
    loadn = 1'b1;
    idle(5);
    checks++;
    if ({mins, sec_tens, sec_ones} !== 12'h307) begin
      errors++;
      $display("[TB] FAIL held_key_release: got %h, want 307", {mins, sec_tens, sec_ones});
    end
  endtask

  task automatic test_countdown();
    do_reset();
    enablen = 1'b1;
    press_key(4'd1);
    press_key(4'd0);
    press_key(4'd0);
    checks++;
    if ({mins, sec_tens, sec_ones} !== 12'h100) begin
      errors++;
      $display("[TB] FAIL load_100: got %h, want 100", {mins, sec_tens, sec_ones});
    end
    enablen = 1'b0;
    idle(1);
    pgt_1hz = 1'b1;
    idle(2);
    checks++;
    if ({mins, sec_tens, sec_ones} !== 12'h100) begin
      errors++;
      $display("[TB] FAIL tick_latency_early: got %h, want 100", {mins, sec_tens, sec_ones});
    end
    idle(1);
    checks++;
    if ({mins, sec_tens, sec_ones} !== 12'h059) begin
      errors++;
      $display("[TB] FAIL borrow_059: got %h, want 059", {mins, sec_tens, sec_ones});
    end
    pgt_1hz = 1'b0;
    idle(4);
    tick();
    checks++;
    if ({mins, sec_tens, sec_ones} !== 12'h058) begin
      errors++;
      $display("[TB] FAIL count_058: got %h, want 058", {mins, sec_tens, sec_ones});
    end
    tick();
    checks++;
    if ({mins, sec_tens, sec_ones} !== 12'h057) begin
      errors++;
      $display("[TB] FAIL count_057: got %h, want 057", {mins, sec_tens, sec_ones});
    end
  endtask

  task automatic test_terminal();
    logic [11:0] expv;
    int          rem;
    do_reset();
    enablen = 1'b1;
    press_key(4'd9);
    press_key(4'd0);
    checks++;
    if ({mins, sec_tens, sec_ones} !== 12'h090) begin
      errors++;
      $display("[TB] FAIL load_090: got %h, want 090", {mins, sec_tens, sec_ones});
    end
    enablen = 1'b0;
`ifdef TIMER_DONE_PULSE_EN
    done_count = 0;
    count_done = 1'b1;
`endif
    for (int n = 1; n <= 91; n++) begin
      tick();
      rem  = (n >= 90) ? 0 : 90 - n;
      expv = {4'd0, 4'(rem / 10), 4'(rem % 10)};
      checks++;
      if ({mins, sec_tens, sec_ones} !== expv || zero !== (rem == 0)) begin
        errors++;
        $display("[TB] FAIL terminal_tick%0d: got %h zero=%b, want %h zero=%b",
                 n, {mins, sec_tens, sec_ones}, zero, expv, (rem == 0));
      end
    end
`ifdef TIMER_DONE_PULSE_EN
    count_done = 1'b0;
    checks++;
    if (done_count !== 1) begin
      errors++;
      $display("[TB] FAIL done_pulses: got %0d, want 1", done_count);
    end
`endif
  endtask

  task automatic test_gating();
    do_reset();
    enablen = 1'b1;
    press_key(4'd4);
    press_key(4'd5);
    checks++;
    if ({mins, sec_tens, sec_ones} !== 12'h045) begin
      errors++;
      $display("[TB] FAIL load_045: got %h, want 045", {mins, sec_tens, sec_ones});
    end
    enablen = 1'b0;
    press_key(4'd7);
    checks++;
    if ({mins, sec_tens, sec_ones} !== 12'h045) begin
      errors++;
      $display("[TB] FAIL load_while_counting: got %h, want 045", {mins, sec_tens, sec_ones});
    end
    enablen = 1'b1;
    tick();
    checks++;
    if ({mins, sec_tens, sec_ones} !== 12'h045) begin
      errors++;
      $display("[TB] FAIL tick_while_idle: got %h, want 045", {mins, sec_tens, sec_ones});
    end
    pgt_1hz = 1'b1;
    idle(5);
    enablen = 1'b0;
    idle(5);
    pgt_1hz = 1'b0;
    idle(4);
    checks++;
    if ({mins, sec_tens, sec_ones} !== 12'h045) begin
      errors++;
      $display("[TB] FAIL tick_not_queued: got %h, want 045", {mins, sec_tens, sec_ones});
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    #2 clearn = 1'b0;
    #1;
    checks++;
    if ({mins, sec_tens, sec_ones} !== 12'h000 || zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_clear: got %h zero=%b, want 000 zero=1", {mins, sec_tens, sec_ones}, zero);
    end
    @(negedge clk);
    clearn = 1'b1;
    idle(1);
    tick();
    checks++;
    if ({mins, sec_tens, sec_ones} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL no_resume_after_clear: got %h, want 000", {mins, sec_tens, sec_ones});
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_invalid();
    test_held_key();
    test_countdown();
    test_terminal();
    test_gating();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Downstream stage of the keypad encoder; consumes its BCD digit, load strobe and 1 Hz tick.
- Holds the entered cook time as three BCD digits (M:ST): minutes, tens of seconds, ones of seconds.
- Digits shift in from the right while idle, then count down once per second while cooking.
- Drives the display digits and a zero flag for the microwave controller.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronizers on loadn and pgt_1hz (minimum 2).

Ports:
- clk  input  1  system clock, single clock domain.
- clearn  input  1  asynchronous active-low reset.
- BCD_IN  input  4  digit from encoder (BCD_OUT); values 10–15 are invalid.
- loadn  input  1  active-low key-valid strobe from encoder; level while key held.
- pgt_1hz  input  1  1 Hz tick from encoder; sampled as data, not used as a clock.
- enablen  input  1  active-low count enable from controller; 1 = idle/entry, 0 = cooking.
- mins  output  4  minutes digit (BCD).
- sec_tens  output  4  tens-of-seconds digit (BCD).
- sec_ones  output  4  ones-of-seconds digit (BCD).
- zero  output  1  high when all three digits are 0; combinational from the digit registers.

Behaviour:
- Reset (clearn low, asynchronous):
  - mins, sec_tens and sec_ones = 0; zero = 1.
  - All synchronizer and edge registers are cleared to their idle levels (loadn path = 1, pgt_1hz path = 0).
- Input synchronisation: loadn and pgt_1hz each pass through a SYNC_STAGES-deep synchronizer, then a one-flop edge detector.
  - load_evt: one-cycle pulse on the synchronized falling edge of loadn.
  - tick_evt: one-cycle pulse on the synchronized rising edge of pgt_1hz.
  - Latency: digits update on the (SYNC_STAGES+1)-th rising clk edge after the input transition.
- Entry, when enablen = 1 and load_evt = 1:
  - Shift left: mins ← sec_tens, sec_tens ← sec_ones, sec_ones ← BCD_IN.
  - If BCD_IN > 9, the load is ignored and the digits are unchanged.
  - A held key produces exactly one load; release and re-press are required.
  - sec_tens may legally hold 6–9 (for example, 90 s entered as "9","0"). No normalisation is applied.
- Countdown, when enablen = 0 and tick_evt = 1. Exactly one step per tick:
  - If sec_ones > 0: decrement sec_ones.
  - Else if sec_tens > 0: sec_tens − 1, sec_ones ← 9.
  - Else if mins > 0: mins − 1, sec_tens ← 5, sec_ones ← 9.
  - Else (all zero): hold at 0. Never wraps below 0:00.
- Loads are ignored while enablen = 0, so load_evt and tick_evt can never both act in one cycle.
- Ticks are ignored while enablen = 1.
- Edge detectors keep running regardless of enablen. An edge that occurs while its action is disabled is discarded, not queued.
- enablen changes act from the same clk edge; there is no pipeline on enablen.
- Reset mid-count clears immediately; counting resumes only after a new entry.
- 9:99 is a legal maximum entry; it counts down through 9:98 and so on.

Optional Feature:
- Macro: TIMER_DONE_PULSE_EN.
- Defined:
  - Adds output port done (1 bit, reset 0).
  - done pulses high for exactly one clk cycle, on the cycle after a countdown step changes the digits from nonzero to all zero.
  - Does not pulse when 0:00 is reached by reset or when counting is enabled with the digits already at 0:00.
- Undefined: port absent; all other behaviour identical.

Decomposition:
- Package timer_pkg:
  - BCD digit typedef (4-bit).
  - Constants BCD_ZERO = 0, BCD_FIVE = 5, BCD_NINE = 9.
  - Default SYNC_STAGES value.
- Sub-module edge_sync: parameterised synchronizer plus edge detector with an edge-polarity parameter.
  - Instantiated twice: loadn on the falling edge, pgt_1hz on the rising edge.
- Digit registers and countdown logic stay in timer_counter.

Test Plan:
- Reset then idle: pulse clearn low → digits 0:00, zero = 1; toggling pgt_1hz with enablen = 0 leaves 0:00 unchanged.
- Entry: enablen = 1; press BCD_IN = 1, 3, 0 with separate loadn pulses → display 1:30, zero = 0; holding loadn low for 50 cycles gives a single shift.
- Invalid digit: from 1:30, load BCD_IN = 12 → still 1:30.
- Countdown borrow: load 1:00, enablen = 0, three ticks → 0:59, 0:58, 0:57; each update lands SYNC_STAGES+1 clk edges after the pgt_1hz rise.
- Terminal and non-normalised: load 0:90 and count 91 ticks → reaches 0:00 after 90 ticks, then holds; zero rises on the 90th; done pulses once when TIMER_DONE_PULSE_EN is defined.
- Gating and mid-reset: loadn pulses during countdown and ticks during entry cause no change; asserting clearn at 0:45 → 0:00 asynchronously, before the next clk edge.
